// File: rtl/bus_burst_fsm.sv
// AHB bus sequencer for one uncached single access or one fixed-length cache-line burst.
// Drives the address-phase controls and tracks data beats until the pipeline releases the bus.
module bus_burst_fsm #(
  parameter int BEATSPERLINE = 4,
  parameter bit BURSTEN      = 1'b1
) (
  input  logic                            HCLK,
  input  logic                            HRESETn,
  input  logic                            Stall,
  input  logic                            Flush,
  input  logic [1:0]                      BusRW,
  input  logic [1:0]                      CacheBusRW,
  input  logic                            HREADY,
  output logic [1:0]                      HTRANS,
  output logic                            HWRITE,
  output logic [2:0]                      HBURST,
  output logic [$clog2(BEATSPERLINE)-1:0] BeatCount,
  output logic                            CaptureEn,
  output logic                            CacheBusAck,
  output logic                            BusStall,
  output logic                            BusCommitted
);

  localparam int BW = $clog2(BEATSPERLINE);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATSPERLINE - 1);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [2:0] INCR_CODE  = (BEATSPERLINE == 16) ? 3'b111 :
                                      (BEATSPERLINE == 8)  ? 3'b101 : 3'b011;
  localparam logic [2:0] BURST_CODE = BURSTEN ? INCR_CODE : 3'b000;
  localparam logic [1:0] BEAT_TRANS = BURSTEN ? TRANS_SEQ : TRANS_NONSEQ;

  typedef enum logic [2:0] {
    ADR_PHASE,
    DATA_PHASE,
    CACHE_FETCH,
    CACHE_WRITEBACK,
    MEM3
  } state_t;

  state_t        state, next_state;
  logic [BW-1:0] next_beat;

  logic in_burst, last_beat, go;
  logic single_req, fetch_req, wb_req;
  logic launch_ok, launch_single, launch_burst;

  assign in_burst   = (state == CACHE_FETCH) || (state == CACHE_WRITEBACK);
  assign last_beat  = (BeatCount == LAST_BEAT);
  assign go         = HREADY & ~Flush;
  assign single_req = |BusRW;
  assign fetch_req  = (BusRW == 2'b00) && (CacheBusRW == 2'b10);
  assign wb_req     = (BusRW == 2'b00) && (CacheBusRW == 2'b01);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ADR_PHASE;
      BeatCount <= '0;
    end else begin
      state     <= next_state;
      BeatCount <= next_beat;
    end
  end

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    unique case (state)
      ADR_PHASE: begin
        if (go) begin
          if (single_req)     next_state = DATA_PHASE;
          else if (fetch_req) next_state = CACHE_FETCH;
          else if (wb_req)    next_state = CACHE_WRITEBACK;
        end
      end
      DATA_PHASE:                  if (HREADY) next_state = MEM3;
      CACHE_FETCH, CACHE_WRITEBACK: if (HREADY && last_beat) next_state = MEM3;
      MEM3:                        if (!Stall) next_state = ADR_PHASE;
      default:                     next_state = ADR_PHASE;
    endcase
    if (Flush) next_state = ADR_PHASE;
  end

  // The beat index only survives while the burst continues; leaving it (done or flushed) clears it.
  always_comb begin
    next_beat = '0;
    if (in_burst && (next_state == state))
      next_beat = HREADY ? BeatCount + BW'(1) : BeatCount;
  end

  // Launch is masked during reset so the bus stays IDLE even with requests pending.
  assign launch_ok     = HRESETn & go & (state == ADR_PHASE);
  assign launch_single = launch_ok & single_req;
  assign launch_burst  = launch_ok & (fetch_req | wb_req);

  always_comb begin
    HTRANS = TRANS_IDLE;
    HBURST = 3'b000;
    HWRITE = 1'b0;
    if (launch_single) begin
      HTRANS = TRANS_NONSEQ;
      HWRITE = BusRW[0];
    end else if (launch_burst) begin
      HTRANS = TRANS_NONSEQ;
      HBURST = BURST_CODE;
      HWRITE = CacheBusRW[0];
    end else if (in_burst) begin
      HBURST = BURST_CODE;
      HWRITE = (state == CACHE_WRITEBACK);
      if (!last_beat && !Flush) HTRANS = BEAT_TRANS;
    end
  end

  assign CacheBusAck  = in_burst & HREADY & last_beat & ~Flush;
  assign CaptureEn    = HREADY & ((state == DATA_PHASE) | (state == CACHE_FETCH));
  assign BusStall     = ((state == ADR_PHASE) & (single_req | (|CacheBusRW)))
                      | (state == DATA_PHASE)
                      | (in_burst & ~CacheBusAck);
  assign BusCommitted = (state != ADR_PHASE);

endmodule

// File: doc/bus_burst_fsm.md
BUS_BURST_FSM -- requirements
Module: bus_burst_fsm

Interface
- REQ-001 SHALL have parameter BEATSPERLINE, default 4, beats per cache-line burst; legal values 4, 8, 16.
- REQ-002 SHALL have parameter BURSTEN, default 1: 1 = fixed-length INCRn bursts with SEQ beats; 0 = every beat issued as SINGLE NONSEQ.
- REQ-003 SHALL have port HCLK  input  1  the single clock; all state changes on its rising edge.
- REQ-004 SHALL have port HRESETn  input  1  reset, asynchronous and active-low.
- REQ-005 SHALL have port Stall  input  1  core pipeline stalled.
- REQ-006 SHALL have port Flush  input  1  stage flush; blocks launch and aborts the FSM.
- REQ-007 SHALL have port BusRW  input  2  uncached single access, 10 read, 01 write, 00 none.
- REQ-008 SHALL have port CacheBusRW  input  2  cache-line burst, 10 fetch, 01 writeback, 00 none.
- REQ-009 SHALL have port HREADY  input  1  AHB subordinate ready.
- REQ-010 SHALL have port HTRANS  output  2  00 IDLE, 10 NONSEQ, 11 SEQ.
- REQ-011 SHALL have port HWRITE  output  1  1 write, 0 read.
- REQ-012 SHALL have port HBURST  output  3  000 SINGLE, 011 INCR4, 101 INCR8, 111 INCR16.
- REQ-013 SHALL have port BeatCount  output  log2(BEATSPERLINE)  index of the current data beat.
- REQ-014 SHALL have port CaptureEn  output  1  HRDATA valid for capture this cycle.
- REQ-015 SHALL have port CacheBusAck  output  1  one-cycle pulse: burst finished.
- REQ-016 SHALL have port BusStall  output  1  transaction in flight, stall pipeline.
- REQ-017 SHALL have port BusCommitted  output  1  FSM not idle; interrupts unsafe.

Function
- REQ-018 SHALL implement states ADR_PHASE, DATA_PHASE, CACHE_FETCH, CACHE_WRITEBACK, MEM3.
- REQ-019 In ADR_PHASE, HREADY & ~Flush & |BusRW SHALL drive HTRANS=NONSEQ, HBURST=000 and go to DATA_PHASE.
- REQ-020 In ADR_PHASE, HREADY & ~Flush & BusRW==00 & CacheBusRW==10 (or 01) SHALL drive HTRANS=NONSEQ and go to CACHE_FETCH (or CACHE_WRITEBACK); BusRW has priority when both are requested.
- REQ-021 In burst states, HTRANS SHALL be SEQ (NONSEQ if BURSTEN=0) while BeatCount < BEATSPERLINE-1, else IDLE; all beat advances are gated by HREADY.
- REQ-022 HBURST SHALL equal the INCRn code for BEATSPERLINE on a burst NONSEQ and throughout burst states when BURSTEN=1; otherwise 000.
- REQ-023 BeatCount SHALL increment on HREADY in burst states, hold when HREADY=0, and be 0 in all other states.
- REQ-024 In a burst state, HREADY with BeatCount==BEATSPERLINE-1 SHALL pulse CacheBusAck and go to MEM3; BeatCount SHALL NOT wrap past the last beat.
- REQ-025 DATA_PHASE SHALL go to MEM3 on HREADY and hold otherwise.
- REQ-026 MEM3 SHALL hold while Stall=1, else go to ADR_PHASE.
- REQ-027 HWRITE SHALL be BusRW[0] on a single launch, CacheBusRW[0] on a burst launch, 1 in CACHE_WRITEBACK, 0 in all other states.
- REQ-028 CaptureEn SHALL be HREADY & (DATA_PHASE | CACHE_FETCH).
- REQ-029 BusStall SHALL be (ADR_PHASE & (|BusRW | |CacheBusRW)) | DATA_PHASE | (burst state & ~CacheBusAck).
- REQ-030 BusCommitted SHALL be 1 in every state other than ADR_PHASE.
- REQ-031 Flush=1 SHALL synchronously force ADR_PHASE and BeatCount=0 from any state, and HTRANS SHALL be IDLE in that cycle.
- REQ-032 HREADY=0 in ADR_PHASE SHALL keep HTRANS=IDLE and leave the state unchanged.

Reset
- REQ-033 HRESETn=0 SHALL immediately (asynchronously) force ADR_PHASE and BeatCount=0, including mid-burst.
- REQ-034 Under reset: HTRANS=00, HBURST=000, CacheBusAck=0, CaptureEn=0, BusCommitted=0, and BusStall reflects only requests on BusRW/CacheBusRW.

Verification
- REQ-035 BusRW=10, HREADY=1 -> NONSEQ/SINGLE in cycle 0, CaptureEn in cycle 1, MEM3 in cycle 2, ADR_PHASE in cycle 3 once Stall=0.
- REQ-036 BEATSPERLINE=4, CacheBusRW=10, HREADY=1 -> HTRANS NONSEQ,SEQ,SEQ,SEQ,IDLE; HBURST=011; BeatCount 0..3; CaptureEn in four cycles; CacheBusAck on beat 3.
- REQ-037 Same burst with HREADY=0 on beat 1 for 2 cycles -> BeatCount holds at 1, HTRANS holds SEQ, and CacheBusAck is delayed by 2 cycles.
- REQ-038 BURSTEN=0, CacheBusRW=01 -> every beat NONSEQ, HBURST=000, HWRITE=1, CaptureEn never asserted.
- REQ-039 Flush on beat 2 of a fetch -> next cycle ADR_PHASE, BeatCount=0, no CacheBusAck; HRESETn low on beat 2 -> same state immediately.
- REQ-040 BusRW=01 and CacheBusRW=10 together -> single write first, burst launched after MEM3 exits.
